// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID/EX pipeline register for the 16-bit MIPS core. Registers every decoded
// control and data field between decode and execute with one cycle of
// latency, and also owns load-use hazard detection: when the instruction it
// holds is a load whose destination is read by the instruction now in
// decode, it asks IF and IF/ID to hold (hazard_stall) and inserts a bubble
// into execute itself. A saturating counter records every bubble inserted,
// whether by a hazard or by squashing a real instruction on flush.
//
// Valid semantics: validout marks that the stage holds a real instruction.
// There is no ready signal; stall_in is the only backpressure and, when
// high, freezes every output including validout. A bubble is validout = 0
// with all control, data, destination and ALU-op fields zero.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid             decode presents a real instruction
//   stall_in             downstream stall: hold all outputs
//   flush                branch taken: squash the stage to a bubble
//   regwrite .. alusrc   decoded control bits
//   data1, data2, offset register operands and sign-extended immediate
//   regdest1, regdest2   rt and rd fields (rt is also a source operand)
//   rs_addr              rs field, used only for the hazard compare
//   aluop                ALU operation
//   *out                 registered copies of the above
//   validout             stage holds a real instruction
//   hazard_stall         combinational load-use stall request to IF, IF/ID
//   bubble_count         saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               stall_in,
    input  logic               flush,
    input  logic               regwrite,
    input  logic               memread,
    input  logic               memwrite,
    input  logic               branch,
    input  logic               memtoreg,
    input  logic               regdst,
    input  logic               alusrc,
    input  logic [DATA_W-1:0]  data1,
    input  logic [DATA_W-1:0]  data2,
    input  logic [DATA_W-1:0]  offset,
    input  logic [REG_W-1:0]   regdest1,
    input  logic [REG_W-1:0]   regdest2,
    input  logic [REG_W-1:0]   rs_addr,
    input  logic [ALUOP_W-1:0] aluop,
    output logic               regwriteout,
    output logic               memreadout,
    output logic               memwriteout,
    output logic               branchout,
    output logic               memtoregout,
    output logic               regdstout,
    output logic               alusrcout,
    output logic [DATA_W-1:0]  data1out,
    output logic [DATA_W-1:0]  data2out,
    output logic [DATA_W-1:0]  offsetout,
    output logic [REG_W-1:0]   regdest1out,
    output logic [REG_W-1:0]   regdest2out,
    output logic [ALUOP_W-1:0] aluopout,
    output logic               validout,
    output logic               hazard_stall,
    output logic [CNT_W-1:0]   bubble_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // -----------------------------------------------------------------------
    // Load-use hazard detection
    // -----------------------------------------------------------------------
    // The held instruction writes rd when regdst is set, rt otherwise.
    logic [REG_W-1:0] ld_dst;
    logic             dst_is_zero;
    logic             dst_match;
    logic             hazard;

    always_comb begin
        ld_dst      = regdstout ? regdest2out : regdest1out;
        dst_is_zero = (ld_dst == '0);
        // regdest1 is the rt field, which is also a source operand.
        dst_match   = (ld_dst == rs_addr) || (ld_dst == regdest1);
        // Register 0 is hard-wired to zero, so writing it creates no hazard.
        hazard      = validout && memreadout && in_valid &&
                      !dst_is_zero && dst_match;
    end

    // A flush discards the consumer anyway, and during a downstream stall
    // the load stays put; the hazard is re-examined once the stall lifts.
    assign hazard_stall = hazard && !flush && !stall_in;

    // -----------------------------------------------------------------------
    // Per-edge action, highest priority first: flush, hold, bubble, load
    // -----------------------------------------------------------------------
    logic do_bubble;
    logic do_load;
    logic count_inc;

    always_comb begin
        do_bubble = flush || hazard_stall;
        do_load   = !flush && !stall_in && !hazard_stall;
        // A flush only counts when it squashes a real instruction.
        count_inc = (flush && in_valid) || hazard_stall;
    end

    // -----------------------------------------------------------------------
    // Control bits
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwriteout <= 1'b0;
            memreadout  <= 1'b0;
            memwriteout <= 1'b0;
            branchout   <= 1'b0;
            memtoregout <= 1'b0;
            regdstout   <= 1'b0;
            alusrcout   <= 1'b0;
        end else if (do_bubble) begin
            regwriteout <= 1'b0;
            memreadout  <= 1'b0;
            memwriteout <= 1'b0;
            branchout   <= 1'b0;
            memtoregout <= 1'b0;
            regdstout   <= 1'b0;
            alusrcout   <= 1'b0;
        end else if (do_load) begin
            // A non-instruction must not carry live side effects into EX.
            regwriteout <= regwrite && in_valid;
            memreadout  <= memread  && in_valid;
            memwriteout <= memwrite && in_valid;
            branchout   <= branch   && in_valid;
            memtoregout <= memtoreg && in_valid;
            regdstout   <= regdst   && in_valid;
            alusrcout   <= alusrc   && in_valid;
        end
    end

    // -----------------------------------------------------------------------
    // Data, destination and ALU-op fields (loaded as-is, even when invalid)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data1out    <= '0;
            data2out    <= '0;
            offsetout   <= '0;
            regdest1out <= '0;
            regdest2out <= '0;
            aluopout    <= '0;
        end else if (do_bubble) begin
            data1out    <= '0;
            data2out    <= '0;
            offsetout   <= '0;
            regdest1out <= '0;
            regdest2out <= '0;
            aluopout    <= '0;
        end else if (do_load) begin
            data1out    <= data1;
            data2out    <= data2;
            offsetout   <= offset;
            regdest1out <= regdest1;
            regdest2out <= regdest2;
            aluopout    <= aluop;
        end
    end

    // -----------------------------------------------------------------------
    // Valid bit
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validout <= 1'b0;
        end else if (do_bubble) begin
            validout <= 1'b0;
        end else if (do_load) begin
            validout <= in_valid;
        end
    end

    // -----------------------------------------------------------------------
    // Bubble counter, saturating at all-ones
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (count_inc && (bubble_count != CNT_MAX)) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    localparam int W = 86;   // 67 field bits + 16-bit count + 3-bit count

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic        in_valid, stall_in, flush;
    logic        regwrite, memread, memwrite, branch, memtoreg, regdst, alusrc;
    logic [15:0] data1, data2, offset;
    logic [3:0]  regdest1, regdest2, rs_addr;
    logic [2:0]  aluop;

    logic        regwriteout, memreadout, memwriteout, branchout, memtoregout, regdstout, alusrcout;
    logic [15:0] data1out, data2out, offsetout;
    logic [3:0]  regdest1out, regdest2out;
    logic [2:0]  aluopout;
    logic        validout, hazard_stall;
    logic [15:0] bubble_count;

    logic        s_regwriteout, s_memreadout, s_memwriteout, s_branchout, s_memtoregout, s_regdstout, s_alusrcout;
    logic [15:0] s_data1out, s_data2out, s_offsetout;
    logic [3:0]  s_regdest1out, s_regdest2out;
    logic [2:0]  s_aluopout;
    logic        s_validout, s_hazard_stall;
    logic [2:0]  s_bubble_count;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
        .regwrite(regwrite), .memread(memread), .memwrite(memwrite), .branch(branch),
        .memtoreg(memtoreg), .regdst(regdst), .alusrc(alusrc),
        .data1(data1), .data2(data2), .offset(offset),
        .regdest1(regdest1), .regdest2(regdest2), .rs_addr(rs_addr), .aluop(aluop),
        .regwriteout(regwriteout), .memreadout(memreadout), .memwriteout(memwriteout),
        .branchout(branchout), .memtoregout(memtoregout), .regdstout(regdstout),
        .alusrcout(alusrcout), .data1out(data1out), .data2out(data2out),
        .offsetout(offsetout), .regdest1out(regdest1out), .regdest2out(regdest2out),
        .aluopout(aluopout), .validout(validout), .hazard_stall(hazard_stall),
        .bubble_count(bubble_count)
    );

    // Narrow-counter instance, driven identically, for saturation behaviour.
    id_ex_pipe_reg #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
        .regwrite(regwrite), .memread(memread), .memwrite(memwrite), .branch(branch),
        .memtoreg(memtoreg), .regdst(regdst), .alusrc(alusrc),
        .data1(data1), .data2(data2), .offset(offset),
        .regdest1(regdest1), .regdest2(regdest2), .rs_addr(rs_addr), .aluop(aluop),
        .regwriteout(s_regwriteout), .memreadout(s_memreadout), .memwriteout(s_memwriteout),
        .branchout(s_branchout), .memtoregout(s_memtoregout), .regdstout(s_regdstout),
        .alusrcout(s_alusrcout), .data1out(s_data1out), .data2out(s_data2out),
        .offsetout(s_offsetout), .regdest1out(s_regdest1out), .regdest2out(s_regdest2out),
        .aluopout(s_aluopout), .validout(s_validout), .hazard_stall(s_hazard_stall),
        .bubble_count(s_bubble_count)
    );

    // ---------------------------------------------------------------- counters
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Architectural view of the stage: what EX sees after each edge.
    logic        m_valid;
    logic [6:0]  m_ctrl;     // {regwrite,memread,memwrite,branch,memtoreg,regdst,alusrc}
    logic [2:0]  m_aluop;
    logic [15:0] m_d1, m_d2, m_off;
    logic [3:0]  m_rd1, m_rd2;
    int          m_cnt, m_cnt3;
    logic [W-1:0] exp_q[$];

    function automatic logic [6:0] ctrl_in();
        return {regwrite, memread, memwrite, branch, memtoreg, regdst, alusrc};
    endfunction

    // Load-use: held load writes a register the decoding instruction reads.
    function automatic logic model_hazard();
        logic [3:0] dst;
        dst = m_ctrl[1] ? m_rd2 : m_rd1;
        return m_valid && m_ctrl[5] && in_valid && (dst != 0) &&
               (dst == rs_addr || dst == regdest1) && !flush && !stall_in;
    endfunction

    function automatic logic [W-1:0] model_pack();
        logic [15:0] c16;
        logic [2:0]  c3;
        c16 = m_cnt[15:0];
        c3  = m_cnt3[2:0];
        return {m_valid, m_ctrl, m_aluop, m_d1, m_d2, m_off, m_rd1, m_rd2, c16, c3};
    endfunction

    task automatic model_zero();
        m_valid = 0; m_ctrl = 0; m_aluop = 0;
        m_d1 = 0; m_d2 = 0; m_off = 0; m_rd1 = 0; m_rd2 = 0;
    endtask

    task automatic model_bump();
        if (m_cnt  < 65535) m_cnt++;
        if (m_cnt3 < 7)     m_cnt3++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_zero();
            m_cnt = 0; m_cnt3 = 0;
        end else if (flush) begin
            if (in_valid) model_bump();
            model_zero();
        end else if (stall_in) begin
            // nothing moves
        end else if (model_hazard()) begin
            model_bump();
            model_zero();
        end else begin
            m_valid = in_valid;
            m_ctrl  = in_valid ? ctrl_in() : 7'd0;
            m_aluop = aluop;
            m_d1 = data1; m_d2 = data2; m_off = offset;
            m_rd1 = regdest1; m_rd2 = regdest2;
        end
        exp_q = {};
        exp_q.push_back(model_pack());
    end

    // ---------------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [82:0]  got;
        logic [69:0]  got_s;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {validout, regwriteout, memreadout, memwriteout, branchout, memtoregout,
                   regdstout, alusrcout, aluopout, data1out, data2out, offsetout,
                   regdest1out, regdest2out, bubble_count};
            got_s = {s_validout, s_regwriteout, s_memreadout, s_memwriteout, s_branchout,
                     s_memtoregout, s_regdstout, s_alusrcout, s_aluopout, s_data1out,
                     s_data2out, s_offsetout, s_regdest1out, s_regdest2out, s_bubble_count};
            total++;
            if (got !== e[85:3]) begin
                bad++;
                $display("FAIL outputs: got %h expected %h (t=%0t)", got, e[85:3], $time);
            end
            total++;
            if (got_s !== {e[85:19], e[2:0]}) begin
                bad++;
                $display("FAIL sat_outputs: got %h expected %h (t=%0t)", got_s, {e[85:19], e[2:0]}, $time);
            end
            chk("hazard_stall", {63'd0, hazard_stall}, {63'd0, model_hazard()});
            chk("sat_hazard_stall", {63'd0, s_hazard_stall}, {63'd0, model_hazard()});
            exp_q.push_back(e);   // keep current expectation until next edge
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; stall_in = 0; flush = 0;
        {regwrite, memread, memwrite, branch, memtoreg, regdst, alusrc} = 7'd0;
        data1 = 0; data2 = 0; offset = 0;
        regdest1 = 0; regdest2 = 0; rs_addr = 0; aluop = 0;
    endtask

    task automatic set_instr(input logic v, input logic [6:0] c, input logic [3:0] rd1,
                             input logic [3:0] rd2, input logic [3:0] rs);
        in_valid = v;
        {regwrite, memread, memwrite, branch, memtoreg, regdst, alusrc} = c;
        regdest1 = rd1; regdest2 = rd2; rs_addr = rs;
    endtask

    // A held load of r3 followed by a consumer of r3: one hazard bubble.
    task automatic load_use_pair();
        set_instr(1, 7'b0100000, 4'd3, 4'd8, 4'd1);
        step();
        set_instr(1, 7'b1000000, 4'd6, 4'd9, 4'd3);
        step();
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst = 1;
        idle_inputs();
        step(); step();
        chk("reset_valid", {63'd0, validout}, 64'd0);
        chk("reset_count", {48'd0, bubble_count}, 64'd0);
        chk("reset_hazard", {63'd0, hazard_stall}, 64'd0);
        rst = 0;

        // pass-through
        set_instr(1, 7'b1000000, 4'd2, 4'd3, 4'd1);
        aluop = 3'b010; data1 = 16'h1234; offset = 16'hFFFC;
        step();
        chk("pt_regwrite", {63'd0, regwriteout}, 64'd1);
        chk("pt_aluop", {61'd0, aluopout}, 64'd2);
        chk("pt_data1", {48'd0, data1out}, 64'h1234);
        chk("pt_offset", {48'd0, offsetout}, 64'hFFFC);
        chk("pt_valid", {63'd0, validout}, 64'd1);

        // stall hold
        data2 = 16'hBEEF;
        step();
        chk("stall_load", {48'd0, data2out}, 64'hBEEF);
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            data2 = 16'($urandom); in_valid = 1'($urandom);
            step();
            chk("stall_data2", {48'd0, data2out}, 64'hBEEF);
            chk("stall_valid", {63'd0, validout}, 64'd1);
        end
        stall_in = 0; in_valid = 1; data2 = 16'h1111;
        step();
        chk("stall_release", {48'd0, data2out}, 64'h1111);

        // flush
        set_instr(1, 7'b0010000, 4'd2, 4'd3, 4'd1);
        step();
        flush = 1;
        step();
        chk("flush_memwrite", {63'd0, memwriteout}, 64'd0);
        chk("flush_valid", {63'd0, validout}, 64'd0);
        chk("flush_count", {48'd0, bubble_count}, 64'd1);
        flush = 0;
        step();
        flush = 1; stall_in = 1;
        step();
        chk("flush_stall_valid", {63'd0, validout}, 64'd0);
        chk("flush_stall_count", {48'd0, bubble_count}, 64'd2);
        flush = 0; stall_in = 0;

        // load-use on rt=5
        set_instr(1, 7'b0100000, 4'd5, 4'd9, 4'd1);
        step();
        set_instr(1, 7'b1000000, 4'd7, 4'd2, 4'd5);
        #1;
        chk("lu_hazard_on", {63'd0, hazard_stall}, 64'd1);
        step();
        chk("lu_bubble_valid", {63'd0, validout}, 64'd0);
        chk("lu_bubble_count", {48'd0, bubble_count}, 64'd3);
        chk("lu_hazard_off", {63'd0, hazard_stall}, 64'd0);
        step();
        chk("lu_consumer_in", {63'd0, validout}, 64'd1);

        // load to r0: no hazard
        set_instr(1, 7'b0100000, 4'd0, 4'd9, 4'd1);
        step();
        set_instr(1, 7'b1000000, 4'd0, 4'd2, 4'd0);
        #1;
        chk("r0_no_hazard", {63'd0, hazard_stall}, 64'd0);

        load_use_pair();
        load_use_pair();
        chk("count_five", {48'd0, bubble_count}, 64'd5);
        set_instr(1, 7'b1000000, 4'd4, 4'd2, 4'd1);
        data1 = 16'hA5A5;
        step();
        chk("pre_rst_valid", {63'd0, validout}, 64'd1);

        // asynchronous reset between edges
        #3 rst = 1;
        #1;
        chk("async_valid", {63'd0, validout}, 64'd0);
        chk("async_count", {48'd0, bubble_count}, 64'd0);
        chk("async_data1", {48'd0, data1out}, 64'd0);
        #1 rst = 0;
        step();
        chk("post_rst_valid", {63'd0, validout}, 64'd1);
        chk("post_rst_data1", {48'd0, data1out}, 64'hA5A5);

        // saturation
        for (int i = 0; i < 10; i++) load_use_pair();
        chk("sat_count3", {61'd0, s_bubble_count}, 64'd7);
        chk("sat_count16", {48'd0, bubble_count}, 64'd10);

        // randomized traffic, small register space so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            stall_in = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            {regwrite, memwrite, branch, memtoreg, regdst, alusrc} = 6'($urandom);
            memread  = ($urandom_range(0, 9) < 4);
            data1 = 16'($urandom); data2 = 16'($urandom); offset = 16'($urandom);
            regdest1 = 4'($urandom_range(0, 3));
            regdest2 = 4'($urandom_range(0, 3));
            rs_addr  = 4'($urandom_range(0, 3));
            aluop    = 3'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1;
                #3 rst = 0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register for the 16-bit MIPS core; successor to the fixed-width stage register.
- Sits between decode and execute and registers all control and data fields with 1-cycle latency.
- Adds asynchronous reset, a valid bit, hold on downstream stall, and flush to a bubble.
- Adds built-in load-use hazard detection: it drives a stall request back to IF/ID and inserts a bubble itself.
- Keeps a saturating count of inserted bubbles for performance monitoring.

Parameters:
DATA_W, 16, width of data1/data2/offset
REG_W, 4, register-address width
ALUOP_W, 3, ALU opcode width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  decode stage presents a real instruction
stall_in  in  1  downstream stall: hold all outputs
flush  in  1  branch taken: squash the stage
regwrite, memread, memwrite, branch, memtoreg, regdst, alusrc  in  1 each  decoded control bits
data1, data2, offset  in  DATA_W each  register operands and sign-extended immediate
regdest1  in  REG_W  rt field (also a source operand)
regdest2  in  REG_W  rd field
rs_addr  in  REG_W  rs field, used for hazard compare only
aluop  in  ALUOP_W  ALU operation
regwriteout, memreadout, memwriteout, branchout, memtoregout, regdstout, alusrcout  out  1 each  registered control bits
data1out, data2out, offsetout  out  DATA_W  registered data
regdest1out, regdest2out  out  REG_W  registered destinations
aluopout  out  ALUOP_W  registered ALU operation
validout  out  1  stage holds a real instruction
hazard_stall  out  1  combinational; IF and IF/ID must hold this cycle
bubble_count  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, any time, including mid-stall): every output register goes to 0, including validout and bubble_count. hazard_stall therefore reads 0.
- Load destination is ld_dst = regdstout ? regdest2out : regdest1out.
- hazard condition = validout & memreadout & in_valid & (ld_dst != 0) & (ld_dst == rs_addr | ld_dst == regdest1).
- hazard_stall = hazard & ~flush & ~stall_in.
- Per-edge priority, highest first:
  1. flush: bubble — all control outputs, data fields and aluopout = 0; validout = 0. bubble_count increments only if in_valid was 1 (a squashed real instruction).
  2. stall_in: all outputs hold, including validout. bubble_count holds.
  3. hazard_stall: bubble as above; bubble_count increments.
  4. Otherwise: every *out <= its input; validout <= in_valid.
- When in_valid = 0 on a normal load: control outputs are forced to 0 regardless of the control inputs. Data fields are loaded as-is.
- bubble_count saturates at 2^CNT_W-1 and never wraps.
- Register 0 never triggers a hazard.
- After a hazard bubble, the held load has advanced to EX/MEM, so validout = 0 and hazard_stall drops the next cycle. Exactly one bubble is inserted per load-use pair.
- flush and hazard in the same cycle: flush wins and hazard_stall = 0.
- stall_in and hazard in the same cycle: hold; hazard_stall = 0. The hazard is re-evaluated after the stall releases.
- No combinational path from any input to a registered output; hazard_stall is the only combinational output.

Test Plan:
- Pass-through: rst pulse, then in_valid=1, regwrite=1, aluop=3'b010, data1=16'h1234, offset=16'hFFFC → next edge: regwriteout=1, aluopout=010, data1out=1234, offsetout=FFFC, validout=1; all were 0 during reset.
- Stall hold: load data2=16'hBEEF, then stall_in=1 for 3 cycles with changing inputs → data2out stays BEEF and validout stays 1; after release, the next input is loaded on the first edge.
- Flush: stage valid with memwrite=1, then flush=1 with in_valid=1 → next edge: all control outputs 0, validout=0, bubble_count=1. flush together with stall_in → flush wins.
- Load-use: load with memread=1, regdst=0, regdest1=4'd5 is held; incoming rs_addr=5 → hazard_stall=1 the same cycle; next edge gives a bubble (validout=0, bubble_count+1); the following cycle hazard_stall=0. Repeat with ld_dst=0 → no hazard.
- Saturation: CNT_W=3, force 10 hazard bubbles → bubble_count reaches 7 and stays at 7.
- Async reset mid-operation: assert rst between edges while validout=1 and bubble_count=5 → outputs clear immediately without waiting for clk; after deassertion, normal loading resumes on the next edge.
